// File: rtl/multicycle_control.sv
// Main control FSM for a multicycle MIPS datapath: fetch/decode/execute/mem/writeback.
// Latency: outputs are combinational from State; lw 5, sw 4, R/addi 4, beq/j 3 cycles.
// Backpressure: FETCH, MEMREAD and MEMWRITE hold while MemReady=0; other states ignore it.
//
// Ports:
//   clk, rst_n            - rising-edge clock, asynchronous active-low reset
//   Opcode                - IR[31:26], valid from DECODE onward
//   MemReady              - shared memory completes the current access this cycle
//   PCWrite/PCWriteCond   - PC load (unconditional / on ALU Zero)
//   IorD, MemRead, MemWrite, IRWrite - memory address select and enables
//   MemtoReg, RegDst, RegWrite       - register-file writeback controls
//   ALUSrcA, ALUSrcB, ALUOp, PCSource - datapath mux selects
//   State, IllegalOp, InstrCount      - debug state, bad-opcode pulse, retired count
module multicycle_control #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       Opcode,
  input  logic             MemReady,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSource,
  output logic [3:0]       State,
  output logic             IllegalOp,
  output logic [CNT_W-1:0] InstrCount
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECUTE  = 4'd6;
  localparam logic [3:0] S_ALUWB    = 4'd7;
  localparam logic [3:0] S_BRANCH   = 4'd8;
  localparam logic [3:0] S_JUMP     = 4'd9;
  localparam logic [3:0] S_ADDIEX   = 4'd10;
  localparam logic [3:0] S_ADDIWB   = 4'd11;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  logic [3:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Raw (ungated) decode of the state-dependent enables.
  logic pc_write, pc_write_cond, mem_write, ir_write, reg_write, illegal;
  logic retire;

  always_comb begin
    state_d       = S_FETCH;
    retire        = 1'b0;
    illegal       = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    IorD          = 1'b0;
    MemRead       = 1'b0;
    MemtoReg      = 1'b0;
    RegDst        = 1'b0;
    ALUSrcA       = 1'b0;
    ALUSrcB       = 2'b00;
    ALUOp         = 2'b00;
    PCSource      = 2'b00;

    case (state_q)
      S_FETCH: begin
        MemRead  = 1'b1;
        ALUSrcB  = 2'b01;
        pc_write = MemReady;
        ir_write = MemReady;
        state_d  = MemReady ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // Speculatively compute the branch target into ALUOut.
        ALUSrcB = 2'b11;
        case (Opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDIEX;
          default: begin
            state_d = S_FETCH;
            illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = (Opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        state_d = MemReady ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        reg_write = 1'b1;
        MemtoReg  = 1'b1;
        retire    = 1'b1;
      end
      S_MEMWRITE: begin
        mem_write = 1'b1;
        IorD      = 1'b1;
        retire    = MemReady;
        state_d   = MemReady ? S_FETCH : S_MEMWRITE;
      end
      S_EXECUTE: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        RegDst    = 1'b1;
        retire    = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA       = 1'b1;
        ALUOp         = 2'b01;
        pc_write_cond = 1'b1;
        PCSource      = 2'b01;
        retire        = 1'b1;
      end
      S_JUMP: begin
        pc_write = 1'b1;
        PCSource = 2'b10;
        retire   = 1'b1;
      end
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
      end
      default: begin
        // Encodings 12-15: all defaults (enables off), recover to FETCH.
        state_d = S_FETCH;
      end
    endcase

    cnt_d = retire ? cnt_q + CNT_W'(1) : cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // While reset is held the FSM sits in FETCH; masking the write-type enables
  // with rst_n keeps an aborted instruction from touching PC, IR, regs or memory.
  assign PCWrite     = pc_write & rst_n;
  assign PCWriteCond = pc_write_cond & rst_n;
  assign MemWrite    = mem_write & rst_n;
  assign IRWrite     = ir_write & rst_n;
  assign RegWrite    = reg_write & rst_n;
  assign IllegalOp   = illegal & rst_n;
  assign State       = state_q;
  assign InstrCount  = cnt_q;

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

  logic       clk;
  logic       rst_n;
  logic [5:0] Opcode;
  logic       MemReady;

  logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic        MemtoReg, RegDst, RegWrite, ALUSrcA, IllegalOp;
  logic [1:0]  ALUSrcB, ALUOp, PCSource;
  logic [3:0]  State;
  logic [31:0] InstrCount;

  // Second instance with a 2-bit counter to observe wrap-around.
  logic        d2_PCWrite, d2_PCWriteCond, d2_IorD, d2_MemRead, d2_MemWrite, d2_IRWrite;
  logic        d2_MemtoReg, d2_RegDst, d2_RegWrite, d2_ALUSrcA, d2_IllegalOp;
  logic [1:0]  d2_ALUSrcB, d2_ALUOp, d2_PCSource;
  logic [3:0]  d2_State;
  logic [1:0]  d2_InstrCount;

  int n_cmp = 0;
  int n_err = 0;

  multicycle_control #(.CNT_W(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .MemReady(MemReady),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .State(State), .IllegalOp(IllegalOp), .InstrCount(InstrCount)
  );

  multicycle_control #(.CNT_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .MemReady(MemReady),
    .PCWrite(d2_PCWrite), .PCWriteCond(d2_PCWriteCond), .IorD(d2_IorD), .MemRead(d2_MemRead),
    .MemWrite(d2_MemWrite), .IRWrite(d2_IRWrite), .MemtoReg(d2_MemtoReg), .RegDst(d2_RegDst),
    .RegWrite(d2_RegWrite), .ALUSrcA(d2_ALUSrcA), .ALUSrcB(d2_ALUSrcB), .ALUOp(d2_ALUOp),
    .PCSource(d2_PCSource), .State(d2_State), .IllegalOp(d2_IllegalOp), .InstrCount(d2_InstrCount)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold reset for one edge, then release; leaves the FSM in FETCH.
  task automatic reset_pulse(input logic [5:0] op, input logic rdy);
    rst_n    = 1'b0;
    Opcode   = op;
    MemReady = rdy;
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    MemReady = 1'b1;
    Opcode   = 6'b000000;
    repeat (3) tick();
    n_cmp++; if (State !== 4'd0) begin n_err++; $display("FAIL reset_state got %0d want 0", State); end
    n_cmp++; if (PCWrite !== 1'b0) begin n_err++; $display("FAIL reset_pcwrite got %b want 0", PCWrite); end
    n_cmp++; if (IRWrite !== 1'b0) begin n_err++; $display("FAIL reset_irwrite got %b want 0", IRWrite); end
    n_cmp++; if (MemRead !== 1'b1) begin n_err++; $display("FAIL reset_memread got %b want 1", MemRead); end
    n_cmp++; if (InstrCount !== 32'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", InstrCount); end
    n_cmp++; if (ALUSrcB !== 2'b01) begin n_err++; $display("FAIL reset_alusrcb got %b want 01", ALUSrcB); end
    n_cmp++; if (IllegalOp !== 1'b0) begin n_err++; $display("FAIL reset_illegal got %b want 0", IllegalOp); end
    rst_n = 1'b1;
    #1;
    n_cmp++; if (PCWrite !== 1'b1 || IRWrite !== 1'b1) begin
      n_err++; $display("FAIL fetch_ready_en got pcw=%b irw=%b want 1 1", PCWrite, IRWrite);
    end
    tick();
    n_cmp++; if (State !== 4'd1) begin n_err++; $display("FAIL reset_release_state got %0d want 1", State); end
  endtask

  task automatic test_lw();
    logic [3:0] seq [6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
    reset_pulse(6'b100011, 1'b1);
    n_cmp++; if (InstrCount !== 32'd0) begin n_err++; $display("FAIL lw_count_start got %0d want 0", InstrCount); end
    for (int i = 0; i < 6; i++) begin
      n_cmp++; if (State !== seq[i]) begin n_err++; $display("FAIL lw_state[%0d] got %0d want %0d", i, State, seq[i]); end
      n_cmp++; if (MemtoReg !== (seq[i] == 4'd4) || RegWrite !== (seq[i] == 4'd4)) begin
        n_err++; $display("FAIL lw_wb[%0d] got m2r=%b rw=%b want %b", i, MemtoReg, RegWrite, seq[i] == 4'd4);
      end
      if (seq[i] == 4'd3) begin
        n_cmp++; if (MemRead !== 1'b1 || IorD !== 1'b1) begin
          n_err++; $display("FAIL lw_memread got mr=%b iord=%b want 1 1", MemRead, IorD);
        end
      end
      if (seq[i] == 4'd2) begin
        n_cmp++; if (ALUSrcA !== 1'b1 || ALUSrcB !== 2'b10) begin
          n_err++; $display("FAIL lw_memadr got a=%b b=%b want 1 10", ALUSrcA, ALUSrcB);
        end
      end
      if (i < 5) tick();
    end
    n_cmp++; if (InstrCount !== 32'd1) begin n_err++; $display("FAIL lw_count_end got %0d want 1", InstrCount); end
  endtask

  task automatic test_rtype_stall();
    reset_pulse(6'b000000, 1'b0);
    for (int k = 0; k < 3; k++) begin
      n_cmp++; if (State !== 4'd0 || PCWrite !== 1'b0 || IRWrite !== 1'b0 || MemRead !== 1'b1) begin
        n_err++; $display("FAIL rt_stall[%0d] got st=%0d pcw=%b irw=%b mr=%b want 0 0 0 1", k, State, PCWrite, IRWrite, MemRead);
      end
      tick();
    end
    MemReady = 1'b1;
    #1;
    n_cmp++; if (State !== 4'd0 || PCWrite !== 1'b1) begin
      n_err++; $display("FAIL rt_ready got st=%0d pcw=%b want 0 1", State, PCWrite);
    end
    tick();
    n_cmp++; if (State !== 4'd1 || ALUSrcB !== 2'b11) begin
      n_err++; $display("FAIL rt_decode got st=%0d b=%b want 1 11", State, ALUSrcB);
    end
    MemReady = 1'b0; // ignored outside memory states
    tick();
    n_cmp++; if (State !== 4'd6 || ALUOp !== 2'b10 || ALUSrcA !== 1'b1 || ALUSrcB !== 2'b00) begin
      n_err++; $display("FAIL rt_exec got st=%0d op=%b a=%b b=%b want 6 10 1 00", State, ALUOp, ALUSrcA, ALUSrcB);
    end
    tick();
    n_cmp++; if (State !== 4'd7 || MemtoReg !== 1'b0 || RegDst !== 1'b1 || RegWrite !== 1'b1) begin
      n_err++; $display("FAIL rt_aluwb got st=%0d m2r=%b rd=%b rw=%b want 7 0 1 1", State, MemtoReg, RegDst, RegWrite);
    end
    tick();
    n_cmp++; if (State !== 4'd0 || InstrCount !== 32'd1) begin
      n_err++; $display("FAIL rt_retire got st=%0d cnt=%0d want 0 1", State, InstrCount);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] st [11] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd0, 4'd1, 4'd8, 4'd0, 4'd1, 4'd9, 4'd0};
    logic [5:0] op [11] = '{6'b101011, 6'b101011, 6'b101011, 6'b101011,
                            6'b000100, 6'b000100, 6'b000100,
                            6'b000010, 6'b000010, 6'b000010, 6'b000010};
    reset_pulse(6'b101011, 1'b1);
    for (int i = 0; i < 11; i++) begin
      Opcode = op[i];
      #1;
      n_cmp++; if (State !== st[i]) begin n_err++; $display("FAIL b2b_state[%0d] got %0d want %0d", i, State, st[i]); end
      n_cmp++; if (MemWrite !== (st[i] == 4'd5)) begin n_err++; $display("FAIL b2b_memwrite[%0d] got %b want %b", i, MemWrite, st[i] == 4'd5); end
      n_cmp++; if (PCWriteCond !== (st[i] == 4'd8)) begin n_err++; $display("FAIL b2b_pcwcond[%0d] got %b want %b", i, PCWriteCond, st[i] == 4'd8); end
      n_cmp++; if (PCWrite !== (st[i] == 4'd0 || st[i] == 4'd9)) begin
        n_err++; $display("FAIL b2b_pcwrite[%0d] got %b want %b", i, PCWrite, st[i] == 4'd0 || st[i] == 4'd9);
      end
      n_cmp++; if ((MemRead & MemWrite) !== 1'b0 || (RegWrite & MemWrite) !== 1'b0) begin
        n_err++; $display("FAIL b2b_invariant[%0d] got mr=%b mw=%b rw=%b want no overlap", i, MemRead, MemWrite, RegWrite);
      end
      if (st[i] == 4'd9) begin
        n_cmp++; if (PCSource !== 2'b10) begin n_err++; $display("FAIL b2b_jump_src got %b want 10", PCSource); end
      end
      if (st[i] == 4'd8) begin
        n_cmp++; if (PCSource !== 2'b01 || ALUOp !== 2'b01) begin
          n_err++; $display("FAIL b2b_beq got src=%b op=%b want 01 01", PCSource, ALUOp);
        end
      end
      if (i < 10) tick();
    end
    n_cmp++; if (InstrCount !== 32'd3) begin n_err++; $display("FAIL b2b_count got %0d want 3", InstrCount); end
  endtask

  task automatic test_illegal();
    reset_pulse(6'b111111, 1'b1);
    n_cmp++; if (State !== 4'd0 || IllegalOp !== 1'b0) begin
      n_err++; $display("FAIL ill_fetch got st=%0d ill=%b want 0 0", State, IllegalOp);
    end
    tick();
    n_cmp++; if (State !== 4'd1 || IllegalOp !== 1'b1) begin
      n_err++; $display("FAIL ill_decode got st=%0d ill=%b want 1 1", State, IllegalOp);
    end
    tick();
    n_cmp++; if (State !== 4'd0 || IllegalOp !== 1'b0 || InstrCount !== 32'd0) begin
      n_err++; $display("FAIL ill_after got st=%0d ill=%b cnt=%0d want 0 0 0", State, IllegalOp, InstrCount);
    end
  endtask

  task automatic test_reset_abort();
    reset_pulse(6'b100011, 1'b1);
    repeat (3) tick();
    MemReady = 1'b0;
    #1;
    n_cmp++; if (State !== 4'd3 || MemRead !== 1'b1 || IorD !== 1'b1) begin
      n_err++; $display("FAIL abort_memread got st=%0d mr=%b iord=%b want 3 1 1", State, MemRead, IorD);
    end
    tick();
    n_cmp++; if (State !== 4'd3) begin n_err++; $display("FAIL abort_stall got %0d want 3", State); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (State !== 4'd0 || InstrCount !== 32'd0) begin
      n_err++; $display("FAIL abort_immediate got st=%0d cnt=%0d want 0 0", State, InstrCount);
    end
    MemReady = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_cmp++; if (RegWrite !== 1'b0 || MemWrite !== 1'b0 || PCWrite !== 1'b0 || IRWrite !== 1'b0) begin
        n_err++; $display("FAIL abort_enables[%0d] got rw=%b mw=%b pcw=%b irw=%b want 0 0 0 0", k, RegWrite, MemWrite, PCWrite, IRWrite);
      end
      tick();
    end
    rst_n = 1'b1;
    tick();
    n_cmp++; if (State !== 4'd1 || InstrCount !== 32'd0) begin
      n_err++; $display("FAIL abort_resume got st=%0d cnt=%0d want 1 0", State, InstrCount);
    end
  endtask

  task automatic test_addi_wrap();
    reset_pulse(6'b001000, 1'b1);
    tick();
    tick();
    n_cmp++; if (State !== 4'd10 || ALUSrcA !== 1'b1 || ALUSrcB !== 2'b10 || ALUOp !== 2'b00) begin
      n_err++; $display("FAIL addi_ex got st=%0d a=%b b=%b op=%b want 10 1 10 00", State, ALUSrcA, ALUSrcB, ALUOp);
    end
    tick();
    n_cmp++; if (State !== 4'd11 || RegWrite !== 1'b1 || RegDst !== 1'b0 || MemtoReg !== 1'b0) begin
      n_err++; $display("FAIL addi_wb got st=%0d rw=%b rd=%b m2r=%b want 11 1 0 0", State, RegWrite, RegDst, MemtoReg);
    end
    tick();
    repeat (12) tick();
    n_cmp++; if (InstrCount !== 32'd4 || d2_InstrCount !== 2'd0) begin
      n_err++; $display("FAIL addi_four got cnt=%0d cnt2=%0d want 4 0", InstrCount, d2_InstrCount);
    end
    repeat (4) tick();
    n_cmp++; if (InstrCount !== 32'd5 || d2_InstrCount !== 2'd1) begin
      n_err++; $display("FAIL addi_wrap got cnt=%0d cnt2=%0d want 5 1", InstrCount, d2_InstrCount);
    end
    n_cmp++; if (d2_State !== 4'd0) begin n_err++; $display("FAIL addi_d2_state got %0d want 0", d2_State); end
  endtask

  initial begin
    rst_n    = 1'b0;
    Opcode   = 6'b000000;
    MemReady = 1'b0;
    test_reset();
    test_lw();
    test_rtype_stall();
    test_back_to_back();
    test_illegal();
    test_reset_abort();
    test_addi_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main control state machine for the multicycle MIPS datapath.
- Sequences fetch, decode, execute, memory and writeback over several clocks.
- Drives every datapath select, including MemtoReg (0 = ALUOut to WriteData, 1 = ReadData to WriteData) and RegDst, and the memory/PC/IR enables.
- Stalls on a shared instruction/data memory ready handshake; counts retired instructions and flags illegal opcodes.

Parameters:
- CNT_W, 32, width of retired-instruction counter InstrCount

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- Opcode  input  6  IR[31:26], valid from DECODE onward
- MemReady  input  1  memory completes current read/write this cycle
- PCWrite  output  1  unconditional PC load
- PCWriteCond  output  1  PC load if ALU Zero (beq)
- IorD  output  1  memory address: 0 = PC, 1 = ALUOut
- MemRead  output  1  memory read request
- MemWrite  output  1  memory write request
- IRWrite  output  1  load instruction register
- MemtoReg  output  1  writeback source: 0 = ALUOut, 1 = ReadData
- RegDst  output  1  destination: 0 = rt, 1 = rd
- RegWrite  output  1  register-file write enable
- ALUSrcA  output  1  0 = PC, 1 = register A
- ALUSrcB  output  2  00 = B, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm << 2
- ALUOp  output  2  00 = add, 01 = sub, 10 = funct-decoded
- PCSource  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- State  output  4  current state encoding (debug)
- IllegalOp  output  1  one-cycle pulse on unsupported opcode
- InstrCount  output  CNT_W  retired instructions

Behaviour:
- States/encodings:
  - FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTE=6, ALUWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11.
  - Encodings 12-15 are unreachable; if entered, go to FETCH next cycle with all enables 0.
- Reset (rst_n low, asynchronous): State=FETCH, InstrCount=0, IllegalOp=0.
- Outputs are decoded combinationally from State; enables marked "gated" are ANDed with MemReady. Values in the reset/FETCH state with MemReady=0:
  - MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - All other outputs 0.
- FETCH:
  - Outputs: MemRead, IorD=0, ALUSrcB=01, ALUOp=00, PCSource=00; PCWrite and IRWrite gated.
  - Stays in FETCH while MemReady=0; goes to DECODE when MemReady=1.
- DECODE:
  - Outputs: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target into ALUOut).
  - Next state by Opcode: 100011/101011 -> MEMADR; 000000 -> EXECUTE; 000100 -> BRANCH; 000010 -> JUMP; 001000 -> ADDIEX.
  - Any other Opcode -> FETCH, with IllegalOp=1 for that DECODE cycle only; no retire.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Opcode 100011 -> MEMREAD; otherwise -> MEMWRITE.
- MEMREAD: MemRead=1, IorD=1. Waits for MemReady, then -> MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0. Retires; -> FETCH.
- MEMWRITE: MemWrite=1, IorD=1. Waits for MemReady; retires on the MemReady cycle; -> FETCH.
- EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=10. -> ALUWB.
- ALUWB: RegWrite=1, MemtoReg=0, RegDst=1. Retires; -> FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01. Retires; -> FETCH.
- JUMP: PCWrite=1, PCSource=10. Retires; -> FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00. -> ADDIWB.
- ADDIWB: RegWrite=1, MemtoReg=0, RegDst=0. Retires; -> FETCH.
- Default: MemtoReg and RegDst are 0 in every state not listed above.
- Invariants:
  - RegWrite and MemWrite are never 1 in the same cycle.
  - MemRead and MemWrite are never both 1.
- Latency without stalls: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3 cycles. Each MemReady=0 cycle in FETCH/MEMREAD/MEMWRITE adds one cycle.
- InstrCount increments by 1 on each retiring cycle and wraps modulo 2^CNT_W.
- Reset asserted mid-instruction aborts it immediately: no further enables, count unchanged from last retire. Release resumes in FETCH.
- MemReady in non-memory states is ignored.

Test Plan:
- Reset, hold rst_n=0 for 3 cycles with MemReady=1 -> State=0, PCWrite=0, IRWrite=0, MemRead=1, InstrCount=0; release, next edge -> State=1.
- lw (Opcode=100011), MemReady held 1 -> State sequence 0,1,2,3,4,0. MemtoReg=1 and RegWrite=1 only in state 4; InstrCount 0->1.
- R-type (Opcode=000000), MemReady=0 for 3 FETCH cycles -> FETCH held 4 cycles with PCWrite=0 until the ready cycle. Then 1,6,7; ALUWB shows MemtoReg=0, RegDst=1.
- sw then beq then j back-to-back -> MemWrite=1 only in state 5; PCWriteCond=1 in state 8; PCSource=10 and PCWrite=1 in state 9; InstrCount=3.
- Opcode=111111 in DECODE -> IllegalOp pulses 1 cycle, next State=0, InstrCount unchanged.
- Reset asserted during MEMREAD stall -> State=0 immediately, MemWrite/RegWrite never pulse. With CNT_W=2 and 5 addi instructions -> InstrCount=1 (wrap).
